// File: rtl/dmem_access_ctrl_if.sv
// Request/response signals of both data-memory requesters plus the memory strobe bus.
// The controller takes the slave view; requesters and the memory take the master view.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic              p0_lb;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic              p1_lb;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_lb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_lb, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_lb, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr, mem_lb,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_lb, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_lb, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_lb,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Round-robin two-port arbiter and SETUP/STROBE/RESP sequencer for the data memory,
// with range checking and per-port read-data holding registers.
module dmem_access_ctrl #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 2);

  state_t            state, state_nxt;
  logic              ptr;
  logic              gnt;
  logic              gnt_nxt;
  logic              take;
  logic              lat_we;
  logic              lat_lb;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              err_q;
  logic              legal;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  // ptr names the preferred port when both request; a lone requester always wins.
  always_comb begin
    take    = bus.p0_req | bus.p1_req;
    gnt_nxt = (bus.p0_req & bus.p1_req) ? ptr : bus.p1_req;
    legal   = lat_lb ? (lat_addr <= LAST_BYTE) : (lat_addr <= LAST_WORD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = SETUP;
      SETUP:   state_nxt = legal ? STROBE : RESP;
      STROBE:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lb is only meaningful on loads, so it is masked at latch time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_lb    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            gnt <= gnt_nxt;
            ptr <= ~gnt_nxt;
            if (gnt_nxt) begin
              lat_we    <= bus.p1_we;
              lat_lb    <= bus.p1_lb & ~bus.p1_we;
              lat_addr  <= bus.p1_addr;
              lat_wdata <= bus.p1_wdata;
            end else begin
              lat_we    <= bus.p0_we;
              lat_lb    <= bus.p0_lb & ~bus.p0_we;
              lat_addr  <= bus.p0_addr;
              lat_wdata <= bus.p0_wdata;
            end
          end
        end
        SETUP: begin
          err_q <= ~legal;
          if (!legal) begin
            if (gnt) rdata1 <= '0;
            else     rdata0 <= '0;
          end
        end
        STROBE: begin
          if (!lat_we) begin
            if (gnt) rdata1 <= bus.mem_rdata;
            else     rdata0 <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr  = lat_addr;
    bus.mem_wdata = lat_wdata;
    bus.mem_lb    = lat_lb;
    bus.mem_rd    = (state == STROBE) & ~lat_we;
    bus.mem_wr    = (state == STROBE) &  lat_we;
    bus.p0_ack    = (state == RESP) & ~gnt;
    bus.p1_ack    = (state == RESP) &  gnt;
    bus.p0_err    = (state == RESP) & ~gnt & err_q;
    bus.p1_err    = (state == RESP) &  gnt & err_q;
    bus.p0_rdata  = rdata0;
    bus.p1_rdata  = rdata1;
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-array memory, directed vector table, dual-request
// and mid-access reset sequences, then random traffic against a transaction-level model.
module tb_dmem_access_ctrl;
  localparam int MEM_BYTES = 32;

  typedef struct {
    bit          we;
    bit          lb;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    bit          p;
    txn_t        t;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic img_load = 1'b1;
  int   total = 0;
  int   bad = 0;

  dmem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(16), .DATA_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] img(int i);
    case (i)
      2:       return 8'h81;
      3:       return 8'h11;
      31:      return 8'hFF;
      default: return 8'(8'h40 + i);
    endcase
  endfunction

  // Memory: combinational read, write on the clock edge while mem_wr is high.
  logic [7:0] ram [MEM_BYTES];

  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_lb) begin
      if (bus.mem_addr < 16'(MEM_BYTES)) bus.mem_rdata = {8'h00, ram[bus.mem_addr[4:0]]};
    end else if (bus.mem_addr < 16'(MEM_BYTES - 1)) begin
      bus.mem_rdata = {ram[bus.mem_addr[4:0] + 5'd1], ram[bus.mem_addr[4:0]]};
    end
  end

  always @(posedge clk) begin
    if (img_load) begin
      for (int i = 0; i < MEM_BYTES; i++) ram[i] <= img(i);
    end else if (bus.mem_wr && bus.mem_addr < 16'(MEM_BYTES - 1)) begin
      ram[bus.mem_addr[4:0]]        <= bus.mem_wdata[7:0];
      ram[bus.mem_addr[4:0] + 5'd1] <= bus.mem_wdata[15:8];
    end
  end

  // Strobe monitor: exclusivity, a low lead-in cycle at the same address, pulse counts.
  logic        prev_strobe = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] s_addr = '0;
  logic [15:0] s_wdata = '0;
  logic        s_lb = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0;
    end else begin
      if (bus.mem_rd || bus.mem_wr) begin
        chk("strobe_exclusive", 32'(bus.mem_rd & bus.mem_wr), 0);
        chk("strobe_lead_low", 32'(prev_strobe), 0);
        chk("strobe_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
        s_addr  = bus.mem_addr;
        s_wdata = bus.mem_wdata;
        s_lb    = bus.mem_lb;
        if (bus.mem_rd) rd_cnt++;
        if (bus.mem_wr) wr_cnt++;
      end
      prev_strobe = bus.mem_rd | bus.mem_wr;
      prev_addr   = bus.mem_addr;
    end
  end

  // Reference model: memory image, per-port held read data, last winner.
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [15:0] exp_rd [2];
  int          last_winner;

  function automatic bit m_err(txn_t t);
    int unsigned span;
    span = (t.lb && !t.we) ? 1 : 2;
    return (32'(t.addr) + span) > MEM_BYTES;
  endfunction

  function automatic logic [15:0] m_read(txn_t t);
    int a;
    a = int'(t.addr);
    if (t.lb) return {8'h00, ref_mem[a]};
    return {ref_mem[a + 1], ref_mem[a]};
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we    = ($urandom_range(0, 2) == 0);
    t.lb    = 1'($urandom_range(0, 1));
    t.addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 33));
    t.wdata = 16'($urandom);
    return t;
  endfunction

  task automatic drive(input int p, input bit req, input txn_t t);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = t.we; bus.p0_lb = t.lb;
      bus.p0_addr = t.addr; bus.p0_wdata = t.wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = t.we; bus.p1_lb = t.lb;
      bus.p1_addr = t.addr; bus.p1_wdata = t.wdata;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.p0_req = 1'b0;
    else        bus.p1_req = 1'b0;
  endtask

  // Issues the active ports' requests at a negedge and follows both to completion.
  task automatic run(input bit [1:0] act, input txn_t t0, input txn_t t1,
                     output logic [15:0] rd0, output logic [15:0] rd1,
                     output bit e0, output bit e1, output int first);
    txn_t        t [2];
    bit          done [2];
    logic [15:0] obs_rd [2];
    bit          obs_err [2];
    int          cyc, exp_at, exp_p, p, rd_base, wr_base, n_rd, n_wr, a;
    bit          e;
    t[0] = t0; t[1] = t1;
    done[0] = !act[0]; done[1] = !act[1];
    obs_rd[0] = '0; obs_rd[1] = '0; obs_err[0] = 1'b0; obs_err[1] = 1'b0;
    first = -1; rd_base = rd_cnt; wr_base = wr_cnt; n_rd = 0; n_wr = 0;
    exp_p  = (act == 2'b11) ? 1 - last_winner : (act[1] ? 1 : 0);
    exp_at = m_err(t[exp_p]) ? 2 : 3;
    drive(0, act[0], t0);
    drive(1, act[1], t1);
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 40) begin
      @(negedge clk); cyc++;
      if (bus.p0_ack || bus.p1_ack) begin
        p = bus.p1_ack ? 1 : 0;
        chk("ack_exclusive", 32'(bus.p0_ack & bus.p1_ack), 0);
        chk("ack_expected", 32'(act[p] && !done[p]), 1);
        chk("grant_order", 32'(p), 32'(exp_p));
        chk("ack_cycle", 32'(cyc), 32'(exp_at));
        if (first < 0) first = p;
        e = m_err(t[p]);
        if (e) begin
          exp_rd[p] = '0;
        end else if (t[p].we) begin
          a = int'(t[p].addr);
          ref_mem[a]     = t[p].wdata[7:0];
          ref_mem[a + 1] = t[p].wdata[15:8];
          n_wr++;
        end else begin
          exp_rd[p] = m_read(t[p]);
          n_rd++;
        end
        obs_rd[p]  = p ? bus.p1_rdata : bus.p0_rdata;
        obs_err[p] = p ? bus.p1_err : bus.p0_err;
        chk("err_flag", 32'(obs_err[p]), 32'(e));
        chk("rdata", 32'(obs_rd[p]), 32'(exp_rd[p]));
        chk("resp_addr_held", 32'(bus.mem_addr), 32'(t[p].addr));
        chk("resp_lb_held", 32'(bus.mem_lb), 32'(t[p].lb & ~t[p].we));
        if (!e) begin
          chk("strobe_addr", 32'(s_addr), 32'(t[p].addr));
          if (t[p].we) chk("strobe_wdata", 32'(s_wdata), 32'(t[p].wdata));
          else         chk("strobe_lb", 32'(s_lb), 32'(t[p].lb));
        end
        last_winner = p;
        done[p] = 1'b1;
        drop(p);
        @(negedge clk); cyc++;
        chk("idle_gap", 32'(busy), 0);
        if (!done[1 - p]) begin
          exp_p  = 1 - p;
          exp_at = cyc + (m_err(t[1 - p]) ? 2 : 3);
        end
      end
    end
    if (!(done[0] && done[1])) begin
      total++; bad++;
      $display("FAIL ack_timeout: got no ack within %0d cycles, want ack", cyc);
      drop(0); drop(1);
    end
    chk("rd_pulses", 32'(rd_cnt - rd_base), 32'(n_rd));
    chk("wr_pulses", 32'(wr_cnt - wr_base), 32'(n_wr));
    rd0 = obs_rd[0]; rd1 = obs_rd[1]; e0 = obs_err[0]; e1 = obs_err[1];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [12];
    txn_t        tz, ta, tb;
    logic [15:0] r0, r1;
    bit          e0, e1;
    int          first;
    bit [1:0]    act;

    vecs[0]  = '{1'b0, '{1'b0, 1'b0, 16'd2,  16'h0000}, 16'h1181, 1'b0};
    vecs[1]  = '{1'b1, '{1'b0, 1'b1, 16'd2,  16'h0000}, 16'h0081, 1'b0};
    vecs[2]  = '{1'b1, '{1'b1, 1'b1, 16'd4,  16'hBEEF}, 16'h0081, 1'b0};
    vecs[3]  = '{1'b0, '{1'b0, 1'b0, 16'd4,  16'h0000}, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b0, '{1'b0, 1'b0, 16'd31, 16'h0000}, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, '{1'b1, 1'b0, 16'd40, 16'h5555}, 16'h0000, 1'b1};
    vecs[6]  = '{1'b0, '{1'b0, 1'b1, 16'd31, 16'h0000}, 16'h00FF, 1'b0};
    vecs[7]  = '{1'b1, '{1'b0, 1'b0, 16'd30, 16'h0000}, 16'hFF5E, 1'b0};
    vecs[8]  = '{1'b1, '{1'b1, 1'b0, 16'd31, 16'hAAAA}, 16'h0000, 1'b1};
    vecs[9]  = '{1'b1, '{1'b0, 1'b1, 16'd32, 16'h0000}, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, '{1'b1, 1'b0, 16'd30, 16'h1234}, 16'h00FF, 1'b0};
    vecs[11] = '{1'b0, '{1'b0, 1'b0, 16'd30, 16'h0000}, 16'h1234, 1'b0};

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = img(i);
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_winner = 1;
    tz = '{1'b0, 1'b0, 16'h0000, 16'h0000};
    drive(0, 1'b0, tz);
    drive(1, 1'b0, tz);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_mem_lb", 32'(bus.mem_lb), 0);
    chk("rst_p0_ack", 32'(bus.p0_ack), 0);
    chk("rst_p1_ack", 32'(bus.p1_ack), 0);
    chk("rst_p0_err", 32'(bus.p0_err), 0);
    chk("rst_p1_err", 32'(bus.p1_err), 0);
    chk("rst_p0_rdata", 32'(bus.p0_rdata), 0);
    chk("rst_p1_rdata", 32'(bus.p1_rdata), 0);
    img_load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run(vecs[i].p ? 2'b10 : 2'b01, vecs[i].t, vecs[i].t, r0, r1, e0, e1, first);
      chk($sformatf("vec%0d_rdata", i), 32'(vecs[i].p ? r1 : r0), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_err", i), 32'(vecs[i].p ? e1 : e0), 32'(vecs[i].exp_err));
    end

    // Simultaneous requests: lone accesses beforehand set up the preferred port.
    ta = '{1'b0, 1'b0, 16'd0, 16'h0000};
    run(2'b10, ta, ta, r0, r1, e0, e1, first);
    ta = '{1'b0, 1'b0, 16'd8, 16'h0000};
    tb = '{1'b1, 1'b0, 16'd8, 16'hCAFE};
    run(2'b11, ta, tb, r0, r1, e0, e1, first);
    chk("dual_a_first", 32'(first), 0);
    chk("dual_a_p0_rdata", 32'(r0), 32'h4948);
    ta = '{1'b0, 1'b0, 16'd0, 16'h0000};
    run(2'b01, ta, ta, r0, r1, e0, e1, first);
    ta = '{1'b0, 1'b1, 16'd9, 16'h0000};
    tb = '{1'b0, 1'b0, 16'd8, 16'h0000};
    run(2'b11, ta, tb, r0, r1, e0, e1, first);
    chk("dual_b_first", 32'(first), 1);
    chk("dual_b_p0_rdata", 32'(r0), 32'h00CA);
    chk("dual_b_p1_rdata", 32'(r1), 32'hCAFE);

    // Reset asserted while a load is strobing.
    ta = '{1'b0, 1'b0, 16'd6, 16'h0000};
    drive(0, 1'b1, ta);
    @(negedge clk);
    @(negedge clk);
    chk("abort_strobe_seen", 32'(bus.mem_rd), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_rd", 32'(bus.mem_rd), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", 32'(bus.p0_rdata), 0);
    drive(0, 1'b0, tz);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(bus.p0_ack | bus.p1_ack), 0);
    end
    last_winner = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    run(2'b01, ta, ta, r0, r1, e0, e1, first);
    chk("post_rst_rdata", 32'(r0), 32'h4746);

    for (int n = 0; n < 80; n++) begin
      act = 2'($urandom_range(1, 3));
      ta  = rnd_txn();
      tb  = rnd_txn();
      run(act, ta, tb, r0, r1, e0, e1, first);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
